icache_fill_ctrl: RTL and testbench

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

---
 rtl/icache_fill_ctrl_pkg.sv | 21 ++
 rtl/icache_fill_ctrl.sv | 175 +++++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_ctrl_pkg.sv
// Shared fetch-side definitions for the instruction-cache fill path:
// fill controller state encoding and line/beat geometry.
package icache_fill_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L2LOOK,
        S_L2CHK,
        S_BEAT0,
        S_BEAT1,
        S_SETTLE,
        S_L1WR,
        S_DONE
    } fill_state_e;

    localparam int BEAT_BYTES    = 16;
    localparam int LINE_BYTES    = 32;
    localparam int LINE_OFS_BITS = $clog2(LINE_BYTES);
    localparam int SETTLE_CYCLES = 3;

endpackage

// File: rtl/icache_fill_ctrl.sv
// L1 instruction-cache miss handler: looks up L2, fetches a 32-byte line as
// two 16-byte bus beats on an L2 miss, then writes the line into L1.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int         AMSB = 79,
    parameter logic [7:0] TMO  = 8'd255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            miss_i,
    input  logic [AMSB:0]   miss_adr_i,
    input  logic            l2_hit_i,
    output logic            cyc_o,
    output logic            stb_o,
    output logic [AMSB:0]   adr_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            exv_i,
    input  logic [127:0]    dat_i,
    output logic            l2_wr_o,
    output logic [AMSB:0]   l2_adr_o,
    output logic [2:0]      l2_cnt_o,
    output logic [127:0]    l2_dat_o,
    output logic            l2_exv_o,
    output logic            l2_err_o,
    output logic            l2_nxt_o,
    output logic            l1_wr_o,
    output logic [AMSB:0]   l1_adr_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int AW = AMSB + 1;

    fill_state_e   state;
    logic [AMSB:0] line;
    logic [AMSB:0] miss_line;
    logic [1:0]    rst_sync;
    logic [7:0]    wait_cnt;
    logic [1:0]    settle_cnt;
    logic          gap;
    logic          tail;
    logic          run_ok;
    logic          resp;
    logic          beat_live;
    logic          beat_end;

    // Reset asserts immediately but releases only after two clock edges, so
    // the first miss after reset is never taken on a metastable release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_ok    = rst_sync[1];
    assign miss_line = {miss_adr_i[AMSB:LINE_OFS_BITS], {LINE_OFS_BITS{1'b0}}};
    assign resp      = ack_i | err_i;
    // BEAT1 also hosts the strobe gap before the beat and the L2 write after it.
    assign beat_live = (state == S_BEAT0) || ((state == S_BEAT1) && !gap && !tail);
    assign beat_end  = beat_live && (resp || (wait_cnt == TMO));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            line       <= '0;
            wait_cnt   <= '0;
            settle_cnt <= '0;
            gap        <= 1'b0;
            tail       <= 1'b0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            adr_o      <= '0;
            l2_wr_o    <= 1'b0;
            l2_adr_o   <= '0;
            l2_cnt_o   <= '0;
            l2_dat_o   <= '0;
            l2_exv_o   <= 1'b0;
            l2_err_o   <= 1'b0;
            l2_nxt_o   <= 1'b0;
            l1_wr_o    <= 1'b0;
            l1_adr_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            l2_wr_o  <= 1'b0;
            l1_wr_o  <= 1'b0;
            done_o   <= 1'b0;
            l2_nxt_o <= 1'b0;

            // A timed-out beat carries no data and is reported as an error.
            if (beat_end) begin
                l2_wr_o  <= 1'b1;
                l2_cnt_o <= (state == S_BEAT1) ? 3'd1 : 3'd0;
                l2_dat_o <= resp ? dat_i : '0;
                l2_exv_o <= resp & exv_i;
                l2_err_o <= err_i | ~resp;
            end

            case (state)
                S_IDLE: begin
                    if (miss_i && run_ok) begin
                        line     <= miss_line;
                        l2_adr_o <= miss_line;
                        busy_o   <= 1'b1;
                        state    <= S_L2LOOK;
                    end
                end
                S_L2LOOK: state <= S_L2CHK;
                S_L2CHK: begin
                    if (l2_hit_i) begin
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end else begin
                        cyc_o    <= 1'b1;
                        stb_o    <= 1'b1;
                        adr_o    <= line;
                        wait_cnt <= '0;
                        state    <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (beat_end) begin
                        stb_o <= 1'b0;
                        adr_o <= line + AW'(BEAT_BYTES);
                        gap   <= 1'b1;
                        state <= S_BEAT1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_BEAT1: begin
                    if (gap) begin
                        gap      <= 1'b0;
                        stb_o    <= 1'b1;
                        wait_cnt <= '0;
                    end else if (tail) begin
                        tail       <= 1'b0;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end else if (beat_end) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        tail  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 2'(SETTLE_CYCLES - 1)) begin
                        l1_wr_o  <= 1'b1;
                        l1_adr_o <= line;
                        state    <= S_L1WR;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                S_L1WR: begin
                    done_o   <= 1'b1;
                    l2_nxt_o <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: each fill is expanded into a
// per-cycle trace of stimulus and expected outputs, then replayed and compared.
module tb_icache_fill_ctrl;

    localparam int AW  = 80;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          miss_i = 1'b0;
    logic [AW-1:0] miss_adr_i = '0;
    logic          l2_hit_i = 1'b0;
    logic          cyc_o, stb_o;
    logic [AW-1:0] adr_o;
    logic          ack_i = 1'b0, err_i = 1'b0, exv_i = 1'b0;
    logic [127:0]  dat_i = '0;
    logic          l2_wr_o;
    logic [AW-1:0] l2_adr_o;
    logic [2:0]    l2_cnt_o;
    logic [127:0]  l2_dat_o;
    logic          l2_exv_o, l2_err_o, l2_nxt_o, l1_wr_o;
    logic [AW-1:0] l1_adr_o;
    logic          busy_o, done_o;

    always #5 clk = ~clk;

    icache_fill_ctrl dut (
        .clk(clk), .rst(rst), .miss_i(miss_i), .miss_adr_i(miss_adr_i),
        .l2_hit_i(l2_hit_i), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o),
        .ack_i(ack_i), .err_i(err_i), .exv_i(exv_i), .dat_i(dat_i),
        .l2_wr_o(l2_wr_o), .l2_adr_o(l2_adr_o), .l2_cnt_o(l2_cnt_o),
        .l2_dat_o(l2_dat_o), .l2_exv_o(l2_exv_o), .l2_err_o(l2_err_o),
        .l2_nxt_o(l2_nxt_o), .l1_wr_o(l1_wr_o), .l1_adr_o(l1_adr_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct {
        bit            start;
        logic          miss, hit, ack, err, exv;
        logic [AW-1:0] madr;
        logic [127:0]  dat;
        logic          busy, cyc, stb, l2wr, l1wr, done, nxt, l2exv, l2err;
        logic [AW-1:0] adr, line, l1adr;
        logic [2:0]    cnt;
        logic [127:0]  l2dat;
    } cyc_t;

    cyc_t sched[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   holdMiss = 0;

    int            l1Off, doneOff, l2N, nxtCnt;
    bit            cycSeen, stbSeen;
    logic [AW-1:0] adrFirst, adrLast, l1AdrCap;
    int            l2Off[4];
    logic [127:0]  l2Dat[4];
    logic          l2Err[4], l2Exv[4];
    logic [2:0]    l2Cnt[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] rand80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[AW-1:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic cyc_t blank();
        cyc_t c;
        c = '{default: '0};
        c.madr = rand80();
        c.dat  = rand128();
        c.hit  = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic cyc_t busyCyc(input logic [AW-1:0] line);
        cyc_t c;
        c = blank();
        c.miss = holdMiss ? 1'b1 : 1'($urandom_range(0, 1));
        c.busy = 1'b1;
        c.line = line;
        return c;
    endfunction

    task automatic addIdle(input int n);
        repeat (n) sched.push_back(blank());
    endtask

    // kind: 0 = ack, 1 = err, 2 = ack and err together; delay > TMO means no response.
    task automatic addFill(input logic [AW-1:0] madr, input bit hit,
                           input int d0, input int d1, input int k0, input int k1,
                           input bit x0, input bit x1, input logic [127:0] a, input logic [127:0] b);
        cyc_t          c;
        logic [AW-1:0] line;
        int            d[2], k[2], last;
        bit            x[2], tmo;
        logic [127:0]  data[2];
        d[0] = d0; d[1] = d1; k[0] = k0; k[1] = k1;
        x[0] = x0; x[1] = x1; data[0] = a; data[1] = b;
        line = {madr[AW-1:5], 5'b0};
        c = blank(); c.start = 1; c.miss = 1'b1; c.madr = madr;
        sched.push_back(c);
        sched.push_back(busyCyc(line));
        c = busyCyc(line); c.hit = hit;
        sched.push_back(c);
        if (!hit) begin
            for (int bt = 0; bt < 2; bt++) begin
                tmo  = d[bt] > TMO;
                last = tmo ? TMO : d[bt];
                for (int i = 0; i <= last; i++) begin
                    c = busyCyc(line);
                    c.cyc = 1'b1; c.stb = 1'b1;
                    c.adr = line + AW'(16 * bt);
                    if (i == d[bt]) begin
                        c.ack = (k[bt] != 1); c.err = (k[bt] != 0);
                        c.exv = x[bt]; c.dat = data[bt];
                    end
                    sched.push_back(c);
                end
                c = busyCyc(line);
                c.cyc   = (bt == 0);
                c.l2wr  = 1'b1;
                c.cnt   = 3'(bt);
                c.l2dat = tmo ? '0 : data[bt];
                c.l2err = tmo || (k[bt] != 0);
                c.l2exv = tmo ? 1'b0 : x[bt];
                sched.push_back(c);
            end
        end
        repeat (3) sched.push_back(busyCyc(line));
        c = busyCyc(line); c.l1wr = 1'b1; c.l1adr = line;
        sched.push_back(c);
        c = busyCyc(line); c.done = 1'b1; c.nxt = 1'b1;
        sched.push_back(c);
    endtask

    task automatic applyStimulus(input cyc_t c);
        miss_i = c.miss; miss_adr_i = c.madr; l2_hit_i = c.hit;
        ack_i = c.ack; err_i = c.err; exv_i = c.exv; dat_i = c.dat;
    endtask

    task automatic checkOutput(input cyc_t c);
        check("busy", busy_o, c.busy);
        check("cyc", cyc_o, c.cyc);
        check("stb", stb_o, c.stb);
        check("l2_wr", l2_wr_o, c.l2wr);
        check("l1_wr", l1_wr_o, c.l1wr);
        check("done", done_o, c.done);
        check("l2_nxt", l2_nxt_o, c.nxt);
        if (c.stb) check("adr", adr_o, c.adr);
        if (c.busy) check("l2_adr", l2_adr_o, c.line);
        if (c.l2wr) begin
            check("l2_cnt", l2_cnt_o, c.cnt);
            check("l2_dat", l2_dat_o, c.l2dat);
            check("l2_exv", l2_exv_o, c.l2exv);
            check("l2_err", l2_err_o, c.l2err);
        end
        if (c.l1wr) check("l1_adr", l1_adr_o, c.l1adr);
    endtask

    task automatic capture(input int off);
        if (cyc_o) cycSeen = 1;
        if (stb_o) begin
            if (!stbSeen) adrFirst = adr_o;
            stbSeen = 1;
            adrLast = adr_o;
        end
        if (l1_wr_o) begin l1Off = off; l1AdrCap = l1_adr_o; end
        if (done_o) doneOff = off;
        if (l2_nxt_o) nxtCnt++;
        if (l2_wr_o && l2N < 4) begin
            l2Off[l2N] = off; l2Dat[l2N] = l2_dat_o; l2Err[l2N] = l2_err_o;
            l2Exv[l2N] = l2_exv_o; l2Cnt[l2N] = l2_cnt_o;
            l2N++;
        end
    endtask

    task automatic runSched(input int limit);
        cyc_t c;
        int   n = 0, off = 0;
        l1Off = -1; doneOff = -1; l2N = 0; nxtCnt = 0;
        cycSeen = 0; stbSeen = 0; adrFirst = '1; adrLast = '1; l1AdrCap = '1;
        for (int i = 0; i < 4; i++) begin
            l2Off[i] = -1; l2Dat[i] = '1; l2Err[i] = 1'bx; l2Exv[i] = 1'bx; l2Cnt[i] = '1;
        end
        while (sched.size() > 0 && n < limit) begin
            c = sched.pop_front();
            @(posedge clk);
            #1 applyStimulus(c);
            @(negedge clk);
            if (c.start) off = 0;
            checkOutput(c);
            capture(off);
            off++;
            n++;
        end
        miss_i = 1'b0; ack_i = 1'b0; err_i = 1'b0;
    endtask

    localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DB = 128'hBBBB_0005_BBBB_0006_BBBB_0007_BBBB_0008;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_cyc", cyc_o, 1'b0);
        check("rst_l2_adr", l2_adr_o, '0);
        check("rst_l1_adr", l1_adr_o, '0);

        // Miss already pending at release must wait for the reset synchroniser.
        miss_adr_i = 80'h1234;
        miss_i = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        check("sync_busy", busy_o, 1'b0);
        miss_i = 1'b0;

        addIdle(4);
        addFill(80'h1234, 1, 0, 0, 0, 0, 0, 0, DA, DB);
        runSched(100000);
        check("hit_cyc_seen", cycSeen, 1'b0);
        check("hit_l1_off", l1Off, 6);
        check("hit_l1_adr", l1AdrCap, 80'h1220);
        check("hit_done_off", doneOff, 7);

        addIdle(2);
        addFill(80'h1234, 0, 1, 1, 0, 0, 0, 0, DA, DB);
        runSched(100000);
        check("miss_adr0", adrFirst, 80'h1220);
        check("miss_adr1", adrLast, 80'h1230);
        check("miss_l2_n", l2N, 2);
        check("miss_wr0_off", l2Off[0], 5);
        check("miss_wr1_off", l2Off[1], 8);
        check("miss_dat0", l2Dat[0], DA);
        check("miss_dat1", l2Dat[1], DB);
        check("miss_cnt1", l2Cnt[1], 3'd1);
        check("miss_l1_off", l1Off, 12);

        addIdle(1);
        addFill(80'h5678, 0, 0, 2, 0, 1, 0, 1, DA, DB);
        runSched(100000);
        check("err_l2_err1", l2Err[1], 1'b1);
        check("err_l2_exv1", l2Exv[1], 1'b1);
        check("err_done_off", doneOff, 13);

        addIdle(1);
        addFill(80'h9abc, 0, 300, 0, 0, 0, 0, 0, DA, DB);
        runSched(100000);
        check("tmo_wr0_off", l2Off[0], 259);
        check("tmo_err0", l2Err[0], 1'b1);
        check("tmo_dat0", l2Dat[0], '0);
        check("tmo_l2_n", l2N, 2);
        check("tmo_err1", l2Err[1], 1'b0);
        check("tmo_dat1", l2Dat[1], DB);

        holdMiss = 1;
        addIdle(1);
        addFill(80'h4440, 0, 1, 2, 0, 0, 0, 0, DA, DB);
        addFill(80'h5550, 1, 0, 0, 0, 0, 0, 0, DA, DB);
        runSched(100000);
        check("hold_nxt_cnt", nxtCnt, 2);
        holdMiss = 0;

        for (int f = 0; f < 40; f++) begin
            addIdle($urandom_range(0, 2));
            addFill(rand80(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rand128(), rand128());
        end
        runSched(100000);

        // Reset in the middle of the second beat's wait.
        addIdle(2);
        addFill(80'hDEAD_0040, 0, 1, 40, 0, 0, 0, 0, DA, DB);
        runSched(12);
        check("pre_rst_stb", stb_o, 1'b1);
        sched.delete();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_cyc", cyc_o, 1'b0);
        check("mid_rst_stb", stb_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_l2_adr", l2_adr_o, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        addIdle(4);
        addFill(80'h2345, 1, 0, 0, 0, 0, 0, 0, DA, DB);
        runSched(100000);
        check("post_rst_l1_off", l1Off, 6);
        check("post_rst_l1_adr", l1AdrCap, 80'h2340);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
